// File: rtl/des_stream_sequencer.sv
// Streams 64-bit blocks from the input SRAM through the 3DES core and writes
// each result to the output SRAM, bounding the number of blocks in flight.
module des_stream_sequencer #(
  parameter int ADDRSIZE     = 14,
  parameter int SRAMWIDTH    = 64,
  parameter int RD_LAT       = 2,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNTW         = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDRSIZE-1:0]  src_base,
  input  logic [ADDRSIZE-1:0]  dst_base,
  input  logic [CNTW-1:0]      block_count,
  output logic [ADDRSIZE-1:0]  src_addr,
  output logic                 src_rden,
  input  logic [SRAMWIDTH-1:0] src_q,
  output logic [ADDRSIZE-1:0]  dst_addr,
  output logic                 dst_wren,
  output logic [SRAMWIDTH-1:0] dst_data,
  output logic                 des_enable,
  output logic [SRAMWIDTH-1:0] raw_data,
  output logic                 data_valid_in,
  input  logic [SRAMWIDTH-1:0] encrypted_data,
  input  logic                 data_valid_out,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic                 err_unexpected,
  output logic [CNTW-1:0]      blocks_done
);

  localparam int IW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDRSIZE-1:0]   src_base_q, src_base_d, dst_base_q, dst_base_d;
  logic [CNTW-1:0]       count_q, count_d, issued_q, issued_d, written_q, written_d;
  logic [IW-1:0]         inflight_q, inflight_d;
  logic [RD_LAT-1:0]     pend_q, pend_d;
  logic [SRAMWIDTH-1:0]  raw_q, raw_d, dst_data_q, dst_data_d;
  logic [ADDRSIZE-1:0]   dst_addr_q, dst_addr_d;
  logic                  dvi_q, dvi_d, wren_q, wren_d, done_q, done_d;
  logic                  aborted_q, aborted_d, err_q, err_d, by_abort_q, by_abort_d;
  logic                  issue, accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      src_base_q <= '0;
      dst_base_q <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      written_q  <= '0;
      inflight_q <= '0;
      pend_q     <= '0;
      raw_q      <= '0;
      dst_data_q <= '0;
      dst_addr_q <= '0;
      dvi_q      <= 1'b0;
      wren_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      by_abort_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_base_q <= src_base_d;
      dst_base_q <= dst_base_d;
      count_q    <= count_d;
      issued_q   <= issued_d;
      written_q  <= written_d;
      inflight_q <= inflight_d;
      pend_q     <= pend_d;
      raw_q      <= raw_d;
      dst_data_q <= dst_data_d;
      dst_addr_q <= dst_addr_d;
      dvi_q      <= dvi_d;
      wren_q     <= wren_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
      by_abort_q <= by_abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_base_d = src_base_q;
    dst_base_d = dst_base_q;
    count_d    = count_q;
    issued_d   = issued_q;
    written_d  = written_q;
    inflight_d = inflight_q;
    raw_d      = raw_q;
    dst_data_d = dst_data_q;
    dst_addr_d = dst_addr_q;
    aborted_d  = aborted_q;
    err_d      = err_q;
    by_abort_d = by_abort_q;
    dvi_d      = 1'b0;
    wren_d     = 1'b0;
    done_d     = 1'b0;
    issue      = 1'b0;
    accept     = data_valid_out && (inflight_q != '0);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_base_d = src_base;
          dst_base_d = dst_base;
          count_d    = block_count;
          issued_d   = '0;
          written_d  = '0;
          inflight_d = '0;
          aborted_d  = 1'b0;
          err_d      = 1'b0;
          by_abort_d = 1'b0;
          state_d    = (block_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        issue = (issued_q < count_q) && (inflight_q < IW'(MAX_INFLIGHT)) && !abort;
        if (abort) begin
          by_abort_d = 1'b1;
          state_d    = S_DRAIN;
        end else if (issued_q == count_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Reads still in the SRAM pipe are already counted in inflight, but
        // checking pend_q too keeps DONE from racing a late read return.
        if (inflight_q == '0 && pend_q == '0) begin
          aborted_d = by_abort_q;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    pend_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) pend_d[i] = pend_q[i-1];

    if (issue) issued_d = issued_q + 1'b1;
    if (issue && !accept)      inflight_d = inflight_q + 1'b1;
    else if (!issue && accept) inflight_d = inflight_q - 1'b1;

    if (pend_q[RD_LAT-1]) begin
      raw_d = src_q;
      dvi_d = 1'b1;
    end

    if (accept) begin
      wren_d     = 1'b1;
      dst_data_d = encrypted_data;
      dst_addr_d = dst_base_q + ADDRSIZE'(written_q);
      written_d  = written_q + 1'b1;
    end

    if (data_valid_out && inflight_q == '0) err_d = 1'b1;
  end

  assign src_rden       = issue;
  assign src_addr       = issue ? (src_base_q + ADDRSIZE'(issued_q)) : '0;
  assign dst_addr       = dst_addr_q;
  assign dst_wren       = wren_q;
  assign dst_data       = dst_data_q;
  assign raw_data       = raw_q;
  assign data_valid_in  = dvi_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign des_enable     = busy;
  assign done           = done_q;
  assign aborted        = aborted_q;
  assign err_unexpected = err_q;
  assign blocks_done    = written_q;

endmodule

// File: tb/tb_des_stream_sequencer.sv
// Bench for des_stream_sequencer: SRAM and DES core models plus directed and
// randomized runs checked against addresses/data computed from run parameters.
module tb_des_stream_sequencer;
  localparam int AW = 14, DW = 64, RDL = 2, MAXI = 4, CW = 14;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [AW-1:0] src_base, dst_base, src_addr, dst_addr;
  logic [CW-1:0] block_count, blocks_done;
  logic          src_rden, dst_wren, des_enable, data_valid_in, data_valid_out;
  logic [DW-1:0] src_q, dst_data, raw_data, encrypted_data;
  logic          busy, done, aborted, err_unexpected;
  logic          dvo_m = 1'b0, dvo_inj = 1'b0;

  always #5 clk = ~clk;
  assign data_valid_out = dvo_m | dvo_inj;

  des_stream_sequencer #(.ADDRSIZE(AW), .SRAMWIDTH(DW), .RD_LAT(RDL),
                         .MAX_INFLIGHT(MAXI), .CNTW(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .block_count(block_count),
    .src_addr(src_addr), .src_rden(src_rden), .src_q(src_q),
    .dst_addr(dst_addr), .dst_wren(dst_wren), .dst_data(dst_data),
    .des_enable(des_enable), .raw_data(raw_data), .data_valid_in(data_valid_in),
    .encrypted_data(encrypted_data), .data_valid_out(data_valid_out),
    .busy(busy), .done(done), .aborted(aborted), .err_unexpected(err_unexpected),
    .blocks_done(blocks_done));

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] mem_seed = 64'h0123_4567_89AB_CDEF, key = 64'h0F1E_2D3C_4B5A_6978;

  function automatic logic [63:0] src_word(input logic [AW-1:0] a);
    return {32'(a) ^ mem_seed[63:32], (~32'(a)) + mem_seed[31:0]};
  endfunction

  function automatic logic [63:0] des_f(input logic [63:0] x);
    return {x[31:0], x[63:32]} ^ key;
  endfunction

  // Input SRAM: data for a read issued in cycle t is on src_q during t+2.
  logic          p1_v = 1'b0;
  logic [AW-1:0] p1_a = '0;
  always @(posedge clk) begin
    p1_v  <= src_rden;
    p1_a  <= src_addr;
    src_q <= p1_v ? src_word(p1_a) : 64'hBAD0_BAD0_BAD0_BAD0;
  end

  // DES core: fixed latency per run, results returned in order.
  int          des_lat = 5;
  int          due_q[$];
  logic [63:0] res_q[$];
  always @(negedge clk) if (data_valid_in) begin
    due_q.push_back(cyc + des_lat);
    res_q.push_back(des_f(raw_data));
  end
  always @(posedge clk) begin
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      dvo_m          = 1'b1;
      encrypted_data = res_q[0];
      due_q.delete(0);
      res_q.delete(0);
    end else begin
      dvo_m = 1'b0;
    end
  end

  // Event logs.
  logic [AW-1:0] rd_addr[$], wr_addr[$];
  logic [63:0]   dvi_data[$], wr_data[$];
  int            rd_cyc[$], dvi_cyc[$], dvo_cyc[$];
  int            done_cnt, done_cyc, busy_seen, max_outst, rd_tot, dvo_tot;

  always @(negedge clk) begin
    if (src_rden) begin
      rd_addr.push_back(src_addr);
      rd_cyc.push_back(cyc);
      rd_tot++;
    end
    if (rd_tot - dvo_tot > max_outst) max_outst = rd_tot - dvo_tot;
    if (data_valid_out) begin
      dvo_cyc.push_back(cyc);
      dvo_tot++;
    end
    if (data_valid_in) begin
      dvi_data.push_back(raw_data);
      dvi_cyc.push_back(cyc);
    end
    if (dst_wren) begin
      wr_addr.push_back(dst_addr);
      wr_data.push_back(dst_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy) busy_seen = 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rd_addr.delete(); wr_addr.delete(); dvi_data.delete(); wr_data.delete();
    rd_cyc.delete(); dvi_cyc.delete(); dvo_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_seen = 0; max_outst = 0; rd_tot = 0; dvo_tot = 0;
    mem_seed = {$urandom, $urandom};
    key      = {$urandom, $urandom};
  endtask

  int start_cyc;
  task automatic go(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n, input int lat);
    des_lat     = lat;
    src_base    = s;
    dst_base    = d;
    block_count = CW'(n);
    start       = 1'b1;
    start_cyc   = cyc;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int b = budget;
    while (done_cnt == 0 && b > 0) begin
      tick();
      b--;
    end
    chk("done_seen", 64'(done_cnt != 0), 64'd1);
    tick(3);
    chk("done_pulses", 64'(done_cnt), 64'd1);
  endtask

  task automatic check_run(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input int nrd, input int nwr);
    chk("rd_count",  64'(rd_addr.size()),  64'(nrd));
    chk("dvi_count", 64'(dvi_data.size()), 64'(nrd));
    chk("wr_count",  64'(wr_addr.size()),  64'(nwr));
    for (int i = 0; i < rd_addr.size() && i < nrd; i++)
      chk($sformatf("rd_addr[%0d]", i), 64'(rd_addr[i]), 64'(AW'(s + i)));
    for (int i = 0; i < dvi_data.size() && i < nrd && i < rd_cyc.size(); i++) begin
      chk($sformatf("dvi_data[%0d]", i), dvi_data[i], src_word(AW'(s + i)));
      chk($sformatf("dvi_lat[%0d]", i), 64'(dvi_cyc[i] - rd_cyc[i]), 64'(RDL + 1));
    end
    for (int i = 0; i < wr_addr.size() && i < nwr; i++) begin
      chk($sformatf("wr_addr[%0d]", i), 64'(wr_addr[i]), 64'(AW'(d + i)));
      chk($sformatf("wr_data[%0d]", i), wr_data[i], des_f(src_word(AW'(s + i))));
    end
    chk("blocks_done", 64'(blocks_done), 64'(nwr));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 64'({src_rden, dst_wren, des_enable, data_valid_in, busy, done,
                            aborted, err_unexpected}), 64'd0);
    chk({tag, "_addr"}, 64'({src_addr, dst_addr, blocks_done}), 64'd0);
    chk({tag, "_raw"}, raw_data, 64'd0);
    chk({tag, "_dst"}, dst_data, 64'd0);
  endtask

  initial begin
    logic [AW-1:0] s, d;
    int n, lat, b;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    src_base = '0; dst_base = '0; block_count = '0;
    clear_logs();
    tick(3);
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // Basic three-block run.
    clear_logs();
    go(14'h0001, 14'h0010, 3, 5);
    wait_done(200);
    check_run(14'h0001, 14'h0010, 3, 3);
    chk("t1_aborted", 64'(aborted), 64'd0);
    chk("t1_err", 64'(err_unexpected), 64'd0);

    // Zero-count start: done only, no traffic.
    clear_logs();
    go(AW'($urandom), AW'($urandom), 0, 3);
    wait_done(50);
    chk("t2_done_delay", 64'(done_cyc - start_cyc), 64'd2);
    chk("t2_rd", 64'(rd_addr.size()), 64'd0);
    chk("t2_wr", 64'(wr_addr.size()), 64'd0);
    chk("t2_dvi", 64'(dvi_data.size()), 64'd0);
    chk("t2_busy", 64'(busy_seen), 64'd0);

    // Inflight limit with a slow core.
    clear_logs();
    s = AW'($urandom); d = AW'($urandom);
    go(s, d, 8, 20);
    wait_done(600);
    check_run(s, d, 8, 8);
    chk("t3_max_inflight", 64'(max_outst), 64'(MAXI));
    if (rd_cyc.size() > 4 && dvo_cyc.size() > 0) begin
      chk("t3_burst", 64'(rd_cyc[3] - rd_cyc[0]), 64'd3);
      chk("t3_stall", 64'(rd_cyc[4] - dvo_cyc[0]), 64'd1);
    end

    // Source address wrap.
    clear_logs();
    d = AW'($urandom);
    go(14'h3FFE, d, 4, $urandom_range(1, 8));
    wait_done(300);
    check_run(14'h3FFE, d, 4, 4);

    // Abort after two issues.
    clear_logs();
    s = AW'($urandom); d = AW'($urandom);
    go(s, d, 6, 10);
    b = 100;
    while (rd_addr.size() < 2 && b > 0) begin
      tick();
      b--;
    end
    abort = 1'b1;
    wait_done(300);
    abort = 1'b0;
    check_run(s, d, 2, 2);
    chk("t5_aborted", 64'(aborted), 64'd1);

    // Unexpected result in IDLE, cleared by the next start.
    clear_logs();
    dvo_inj = 1'b1;
    tick();
    dvo_inj = 1'b0;
    tick(2);
    chk("t6_err_set", 64'(err_unexpected), 64'd1);
    chk("t6_no_write", 64'(wr_addr.size()), 64'd0);
    clear_logs();
    s = AW'($urandom); d = AW'($urandom);
    go(s, d, 2, 3);
    chk("t6_err_clr", 64'(err_unexpected), 64'd0);
    chk("t6_abort_clr", 64'(aborted), 64'd0);
    wait_done(200);
    check_run(s, d, 2, 2);

    // Reset in the middle of a run.
    clear_logs();
    go(AW'($urandom), AW'($urandom), 10, 30);
    b = 100;
    while (rd_addr.size() < 3 && b > 0) begin
      tick();
      b--;
    end
    chk("t6_busy_before_rst", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("midrun_reset");
    due_q.delete();
    res_q.delete();
    reset = 1'b0;
    tick(5);
    chk("t6_idle_after_rst", 64'({busy, src_rden, dst_wren}), 64'd0);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      clear_logs();
      s   = AW'($urandom);
      d   = AW'($urandom);
      n   = $urandom_range(1, 12);
      lat = $urandom_range(1, 25);
      go(s, d, n, lat);
      wait_done(200 + n * 40);
      check_run(s, d, n, n);
      chk("rand_inflight_le_max", 64'(max_outst <= MAXI), 64'd1);
      chk("rand_flags", 64'({aborted, err_unexpected}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/des_stream_sequencer.md
Name: des_stream_sequencer

Overview:
- Sequences the 3DES datapath of the ECCDH3DES core across a block stream.
- Reads 64-bit plaintext/ciphertext blocks from the input SRAM, feeds each block to the core with a data_valid_in pulse, and writes each data_valid_out result to the output SRAM.
- Replaces the ad-hoc address/flag logic in the Avalon wrapper; the CSR layer only programs base addresses and count, issues start, and polls status.

Parameters:
- ADDRSIZE, 14, SRAM address width.
- SRAMWIDTH, 64, SRAM and DES block width.
- RD_LAT, 2, cycles from src_rden to valid src_q (1..4).
- MAX_INFLIGHT, 4, maximum blocks issued to DES but not yet written back (1..15).
- CNTW, 14, width of the block counters.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- abort  in  1  level; stops issue and drains in-flight blocks.
- src_base  in  ADDRSIZE  first input SRAM address; latched on start.
- dst_base  in  ADDRSIZE  first output SRAM address; latched on start.
- block_count  in  CNTW  number of blocks; latched on start.
- src_addr  out  ADDRSIZE  input SRAM address.
- src_rden  out  1  input SRAM read enable.
- src_q  in  SRAMWIDTH  input SRAM read data.
- dst_addr  out  ADDRSIZE  output SRAM address.
- dst_wren  out  1  output SRAM write enable.
- dst_data  out  SRAMWIDTH  output SRAM write data.
- des_enable  out  1  drives the core's des_start.
- raw_data  out  SRAMWIDTH  block to core.
- data_valid_in  out  1  one-cycle qualifier for raw_data.
- encrypted_data  in  SRAMWIDTH  core result.
- data_valid_out  in  1  core result qualifier.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle completion pulse.
- aborted  out  1  sticky; set if the run ended by abort; cleared on start.
- err_unexpected  out  1  sticky; set on data_valid_out while inflight==0; cleared on start.
- blocks_done  out  CNTW  blocks written in the current or last run.

Behaviour:
- Reset: all outputs 0; state IDLE; all counters 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start && block_count!=0 -> RUN. Latch bases and count; clear issued, written, inflight, blocks_done, aborted, err_unexpected.
  - start && block_count==0 -> DONE. No SRAM or DES activity.
  - start outside IDLE is ignored.
- RUN, issue rule: issue a read when issued<count, inflight<MAX_INFLIGHT and !abort.
  - On issue: src_rden=1 for exactly that cycle; src_addr=src_base+issued, modulo 2^ADDRSIZE; issued++.
  - At most one issue per cycle; back-to-back issues are allowed.
- Read return: a RD_LAT-deep valid shift register tracks each issue.
  - When a tracked issue emerges, src_q is registered into raw_data and data_valid_in=1 for one cycle.
  - data_valid_in therefore asserts RD_LAT+1 cycles after src_rden.
  - raw_data holds its value otherwise.
- Write-back: on data_valid_out with inflight>0, the next cycle asserts dst_wren=1, dst_data=encrypted_data (registered) and dst_addr=dst_base+written (mod 2^ADDRSIZE); then written++ and blocks_done++.
- Inflight count: +1 on issue, -1 on write-back acceptance; unchanged when both happen in the same cycle. It never exceeds MAX_INFLIGHT.
- Unexpected result: data_valid_out with inflight==0 sets err_unexpected and produces no write.
- RUN -> DRAIN when issued==count or abort is seen.
- DRAIN: no new issues. Go to DONE when inflight==0 and no read is still pending in the shift register. If abort caused the drain, set aborted.
- DONE: done=1 for one cycle, then IDLE. blocks_done holds until the next start.
- des_enable = busy.
- abort in IDLE or DONE has no effect. abort deasserted during DRAIN does not resume issue.
- reset mid-run: returns to IDLE in the next cycle; SRAM enables are low in that cycle.

Test Plan:
1. src_base=1, dst_base=0x10, count=3, DES model with 5-cycle latency.
   - src_rden at 0x1, 0x2, 0x3.
   - data_valid_in RD_LAT+1 cycles after each read.
   - dst writes at 0x10..0x12 with matching data.
   - done pulse, blocks_done=3.
2. count=0 start -> done two cycles later; no src_rden, dst_wren or data_valid_in; busy stays 0.
3. MAX_INFLIGHT=4, count=8, DES latency 20.
   - Exactly 4 reads, then a stall until the first write-back.
   - inflight never exceeds 4.
   - All 8 written in order.
4. src_base=0x3FFE, count=4 -> src_addr sequence 3FFE, 3FFF, 0000, 0001 (wrap).
5. abort asserted after 2 issues of count=6 -> no further reads; 2 writes complete; done with aborted=1, blocks_done=2.
6. Run with an injected data_valid_out in IDLE -> err_unexpected=1, no write.
   - Then a start clears it.
   - Then reset asserted mid-RUN -> IDLE, all outputs 0 the following cycle.
